alu_share_rr: RTL and testbench
===============================

Name: alu_share_rr

Overview:
- Parametrised successor to the single-ALU time-multiplexed datapath.
- NUM_CH requesters share one registered ALU of WIDTH bits, arbitrated round-robin.
- Each requester has a valid/ready request port; there is one shared response port with backpressure, tagged with the channel ID.
- Intended as the shared arithmetic unit in small MCU-class subsystems where several masters need occasional ALU ops.

Parameters:
- WIDTH, 8, operand/result width (>=2).
- NUM_CH, 4, number of requesting channels (>=1).
- CH_W, $clog2(NUM_CH) (min 1), channel-ID width; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept (one-hot or zero).
- req_op  in  3*NUM_CH  per-channel opcode; channel i occupies [3i+2:3i].
- req_a  in  WIDTH*NUM_CH  per-channel operand A.
- req_b  in  WIDTH*NUM_CH  per-channel operand B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_ch  out  CH_W  channel ID that issued the result.
- rsp_data  out  WIDTH  result.
- rsp_carry  out  1  carry-out (ADD), borrow (SUB), 0 otherwise.
- rsp_zero  out  1  rsp_data == 0.
- busy  out  1  any pipeline stage occupied.

Behaviour:
- Opcodes:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: a << b[log2(WIDTH)-1:0]
  - 110 SHR, logical: a >> same shift amount
  - 111 PASS: a
- Arithmetic is modulo 2^WIDTH. Carry comes from the WIDTH+1-bit sum/difference; borrow = 1 when a < b unsigned.
- Pipeline:
  - S1: operand register holding op, a, b, ch, plus valid bit v1.
  - S2: output register holding rsp_* fields.
  - ALU is combinational between S1 and S2.
- Advance rules:
  - s2_free = !rsp_valid | rsp_ready.
  - S1 advances into S2 when v1 & s2_free.
  - A new grant is allowed when !v1 | s2_free.
- Arbiter:
  - Round-robin pointer last_gnt, reset value NUM_CH-1, so ch0 wins first.
  - Search order is last_gnt+1 .. last_gnt, wrapping modulo NUM_CH.
  - req_ready[i] = grant_allowed & (i is the first valid channel in search order).
  - req_ready depends combinationally on req_valid (documented; no loop, because requesters must not gate valid on ready).
  - last_gnt updates only on an accepted handshake.
- Latency: request accepted at edge N -> rsp_valid=1 after edge N+1, with no backpressure.
- Throughput: 1 op/cycle sustained.
- Backpressure:
  - With rsp_valid & !rsp_ready, all rsp_* fields hold stable.
  - S1 stays full and no new grants are issued.
- Hold: after a response handshake with no new result, rsp_valid drops to 0 and rsp_data/rsp_ch/flags retain their last values (not cleared).
- Simultaneous events:
  - A response consumed and S1 advancing on the same edge loads S2 with the new result; rsp_valid stays 1.
  - Grant and advance on the same edge reload S1.
- Reset (any time, including mid-operation):
  - v1=0, rsp_valid=0, rsp_data=0, rsp_ch=0, rsp_carry=0, rsp_zero=0, last_gnt=NUM_CH-1.
  - req_ready=0 while rst_n=0.
  - In-flight ops are dropped.
- busy = v1 | rsp_valid.
- NUM_CH=1: arbiter degenerates to pass-through; rsp_ch is always 0.

Decomposition:
- Package alu_share_pkg holds:
  - alu_op_e enum (3-bit, values as listed above).
  - Result/flag struct {data, carry, zero}.
  - Function alu_eval(op, a, b), parameterised by WIDTH via a WIDTH-sized package localparam or a function in a parameterised class.
- Sub-module rr_arbiter #(N) owns the pointer and issues a one-hot grant from req + enable.
  - Pointer updates on enable & |req.
  - Reused elsewhere.
- Top level holds the S1/S2 registers and the ALU instance.

Test Plan (WIDTH=8, NUM_CH=4):
- Reset, then ch0 sends ADD a=0xF0 b=0x20 with rsp_ready=1.
  - Expect req_ready[0]=1 in that cycle.
  - Two edges later: rsp_valid=1, rsp_data=0x10, rsp_carry=1, rsp_zero=0, rsp_ch=0.
- All 4 channels hold valid continuously (ch i: SUB a=i b=i) with rsp_ready=1.
  - Expect grants in order 0,1,2,3,0, one per cycle.
  - Each result has rsp_data=0x00 and rsp_zero=1.
- Op sweep on ch2 with a=0x81, b=0x03, expected rsp_data in order:
  - ADD 0x84
  - SUB 0x7E (carry=0)
  - AND 0x01
  - OR 0x83
  - XOR 0x82
  - SHL 0x08
  - SHR 0x10
  - PASS 0x81
  - Then SUB a=0x01 b=0x02 -> 0xFF with carry=1.
- Backpressure: hold rsp_ready=0 for 5 cycles with ch1 and ch3 requesting.
  - Expect rsp_* stable throughout, one op parked in S1, and req_ready all 0.
  - On release, two results arrive on consecutive cycles, ch1 first.
- Assert rst_n=0 asynchronously mid-cycle while S1 and S2 are full.
  - Expect rsp_valid=0 and busy=0 immediately (no clock edge needed).
  - After release, ch0 has first priority and no stale result appears.
- After one result is consumed with no new request, rsp_valid=0 and rsp_data keeps its previous value.

Source files
------------

// File: rtl/alu_share_rr_pkg.sv
// Shared opcode, result types and the width-generic ALU evaluation function
// for the round-robin shared ALU.
package alu_share_pkg;

  // Widest datapath alu_eval supports; callers zero-extend and pass their width.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             carry;
    logic             zero;
  } alu_res_t;

  // Operands must already be confined to the low w bits; result is masked to w bits.
  function automatic alu_res_t alu_eval(input alu_op_e          op,
                                        input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input int unsigned      sh,
                                        input int unsigned      w);
    alu_res_t         r;
    logic [MAX_W:0]   wide;
    logic [MAX_W-1:0] mask;
    r    = '0;
    wide = '0;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        r.data  = wide[MAX_W-1:0];
        r.carry = ((wide >> w) != '0);
      end
      OP_SUB: begin
        r.data  = a - b;
        r.carry = (a < b);
      end
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_XOR:  r.data = a ^ b;
      OP_SHL:  r.data = a << sh;
      OP_SHR:  r.data = a >> sh;
      default: r.data = a;
    endcase
    r.data = r.data & mask;
    r.zero = (r.data == '0);
    return r;
  endfunction

endpackage

// File: rtl/alu_share_rr_if.sv
// Request/response bundle for the shared ALU: per-channel valid/ready requests
// in, one tagged response stream with backpressure out.
interface alu_share_rr_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH-1:0]       req_ready;
  logic [3*NUM_CH-1:0]     req_op;
  logic [WIDTH*NUM_CH-1:0] req_a;
  logic [WIDTH*NUM_CH-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [CH_W-1:0]         rsp_ch;
  logic [WIDTH-1:0]        rsp_data;
  logic                    rsp_carry;
  logic                    rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_ch, rsp_data, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_ch, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_share_rr_arb.sv
// Round-robin arbiter: one-hot grant from req/enable, searching from the
// channel after the last one granted.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] win;
  logic [PW-1:0] sel;
  logic [N-1:0]  gnt;
  logic          found;
  int unsigned   idx;

  always_comb begin
    gnt   = '0;
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = int'(last_q) + off;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req_i[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        win      = sel;
      end
    end
    gnt_o  = en_i ? gnt : '0;
    last_d = (en_i && found) ? win : last_q;
  end

  // Reset to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_share_rr.sv
// NUM_CH requesters share one registered ALU: round-robin grant into an operand
// register (S1), combinational ALU, and a backpressured output register (S2).
module alu_share_rr
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_rr_if.slave    bus,
  output logic             busy
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SH_W = $clog2(WIDTH);

  logic             v1_q, v1_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CH_W-1:0]  rsp_ch_q, rsp_ch_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic [NUM_CH-1:0] gnt;
  logic              s2_free, advance, grant_ok, accept;
  logic [CH_W-1:0]   sel_ch;
  logic [2:0]        sel_op;
  logic [WIDTH-1:0]  sel_a, sel_b;
  alu_res_t          res;
  logic              unused_alu;

  assign s2_free  = !rsp_valid_q || bus.rsp_ready;
  assign advance  = v1_q && s2_free;
  assign grant_ok = (!v1_q || s2_free) && rst_n;
  assign accept   = |gnt;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.req_valid),
    .en_i  (grant_ok),
    .gnt_o (gnt)
  );

  always_comb begin
    sel_ch = '0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_ch = CH_W'(i);
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign res = alu_eval(op_q, MAX_W'(a_q), MAX_W'(b_q),
                        int'(b_q[SH_W-1:0]), WIDTH);
  assign unused_alu = ^res.data;

  // A grant is only issued when S1 is empty or draining, so loading S1 has priority.
  always_comb begin
    v1_d        = v1_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    ch_d        = ch_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ch_d    = rsp_ch_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    if (accept) begin
      v1_d = 1'b1;
      op_d = alu_op_e'(sel_op);
      a_d  = sel_a;
      b_d  = sel_b;
      ch_d = sel_ch;
    end else if (advance) begin
      v1_d = 1'b0;
    end
    if (advance) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = res.data[WIDTH-1:0];
      rsp_ch_d    = ch_q;
      rsp_carry_d = res.carry;
      rsp_zero_d  = res.zero;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      ch_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ch_q    <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ch_q        <= ch_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ch    = rsp_ch_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = v1_q || rsp_valid_q;

endmodule

// File: tb/tb_alu_share_rr.sv
// Bench for alu_share_rr (WIDTH=8, NUM_CH=4): directed scenarios plus a random
// run against a transaction-level model (RR winner, 2-deep pipe, in-order results).
module tb_alu_share_rr;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_rr_if #(.WIDTH(8), .NUM_CH(4)) bus ();

  alu_share_rr #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    int ch;
    int data;
    bit carry;
    int t;
  } exp_t;

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int d, output bit c);
    int s;
    c = 1'b0;
    case (op)
      0: begin s = a + b; d = s % 256; c = (s > 255); end
      1: begin d = (a - b + 256) % 256; c = (a < b); end
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: d = (a * (1 << (b % 8))) % 256;
      6: d = a / (1 << (b % 8));
      default: d = a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[ch]      = 1'b1;
    bus.req_op[3*ch +: 3]  = op;
    bus.req_a[8*ch +: 8]   = a;
    bus.req_b[8*ch +: 8]   = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 8'h00 || bus.rsp_ch !== 2'd0 || bus.rsp_carry !== 1'b0 || bus.rsp_zero !== 1'b0)
      begin n_fail++; $display("FAIL reset_rsp_fields: got data=%h ch=%0d c=%b z=%b expected 00/0/0/0", bus.rsp_data, bus.rsp_ch, bus.rsp_carry, bus.rsp_zero); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    clear_reqs();
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    set_req(0, 3'b000, 8'hF0, 8'h20);
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL add_ready: got %b expected 0001", bus.req_ready); end
    tick();
    clear_reqs();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: got rsp_valid=%b expected 0", bus.rsp_valid); end
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 8'h10) begin n_fail++; $display("FAIL add_data: got %h expected 10", bus.rsp_data); end
    n_tests++; if (bus.rsp_carry !== 1'b1 || bus.rsp_zero !== 1'b0) begin n_fail++; $display("FAIL add_flags: got c=%b z=%b expected c=1 z=0", bus.rsp_carry, bus.rsp_zero); end
    n_tests++; if (bus.rsp_ch !== 2'd0) begin n_fail++; $display("FAIL add_ch: got %0d expected 0", bus.rsp_ch); end
  endtask

  task automatic test_hold();
    bus.rsp_ready = 1'b1;
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 8'h10 || bus.rsp_carry !== 1'b1 || bus.rsp_ch !== 2'd0)
      begin n_fail++; $display("FAIL hold_fields: got data=%h c=%b ch=%0d expected 10/1/0", bus.rsp_data, bus.rsp_carry, bus.rsp_ch); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'b001, 8'(i), 8'(i));
    for (int k = 0; k <= 6; k++) begin
      if (k == 5) clear_reqs();
      #1;
      if (k < 5) begin
        n_tests++; if (bus.req_ready !== (4'b0001 << (k % 4)))
          begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, 4'b0001 << (k % 4)); end
      end
      if (k >= 2) begin
        n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00 || bus.rsp_zero !== 1'b1 || bus.rsp_ch !== 2'((k - 2) % 4))
          begin n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b data=%h z=%b ch=%0d expected 1/00/1/%0d", k, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_ch, (k - 2) % 4); end
      end
      tick();
    end
  endtask

  task automatic test_op_sweep();
    logic [2:0] ops [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [7:0] as  [9] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h01};
    logic [7:0] bs  [9] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02};
    logic [7:0] ed  [9] = '{8'h84, 8'h7E, 8'h01, 8'h83, 8'h82, 8'h08, 8'h10, 8'h81, 8'hFF};
    logic       ec  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k < 9) set_req(2, ops[k], as[k], bs[k]);
      else clear_reqs();
      #1;
      if (k < 9) begin
        n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL sweep_ready[%0d]: got %b expected 0100", k, bus.req_ready); end
      end
      if (k >= 2) begin
        n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ed[k-2] || bus.rsp_carry !== ec[k-2] || bus.rsp_zero !== 1'b0 || bus.rsp_ch !== 2'd2)
          begin n_fail++; $display("FAIL sweep_rsp[%0d]: got v=%b data=%h c=%b z=%b ch=%0d expected 1/%h/%b/0/2", k - 2, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_ch, ed[k-2], ec[k-2]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(1, 3'b000, 8'h01, 8'h01);
    set_req(3, 3'b100, 8'h0F, 8'hF0);
    #1;
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant: got %b expected 0010", bus.req_ready); end
    tick();
    #1;
    n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_second_grant: got %b expected 1000", bus.req_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h02 || bus.rsp_ch !== 2'd1 || bus.rsp_carry !== 1'b0 || bus.rsp_zero !== 1'b0)
        begin n_fail++; $display("FAIL bp_stall_rsp[%0d]: got v=%b data=%h ch=%0d c=%b z=%b expected 1/02/1/0/0", k, bus.rsp_valid, bus.rsp_data, bus.rsp_ch, bus.rsp_carry, bus.rsp_zero); end
      n_tests++; if (bus.req_ready !== 4'b0000 || busy !== 1'b1)
        begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got ready=%b busy=%b expected 0000/1", k, bus.req_ready, busy); end
      tick();
    end
    clear_reqs();
    bus.rsp_ready = 1'b1;
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'd3 || bus.rsp_data !== 8'hFF || bus.rsp_zero !== 1'b0)
      begin n_fail++; $display("FAIL bp_second_rsp: got v=%b ch=%0d data=%h z=%b expected 1/3/FF/0", bus.rsp_valid, bus.rsp_ch, bus.rsp_data, bus.rsp_zero); end
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'hFF || busy !== 1'b0)
      begin n_fail++; $display("FAIL bp_drain: got v=%b data=%h busy=%b expected 0/FF/0", bus.rsp_valid, bus.rsp_data, busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(0, 3'b000, 8'h05, 8'h06);
    set_req(2, 3'b011, 8'h30, 8'h03);
    tick();
    tick();
    clear_reqs();
    n_tests++; if (bus.rsp_valid !== 1'b1 || busy !== 1'b1 || bus.rsp_data !== 8'h0B)
      begin n_fail++; $display("FAIL arst_pre: got v=%b busy=%b data=%h expected 1/1/0B", bus.rsp_valid, busy, bus.rsp_data); end
    set_req(3, 3'b111, 8'hAA, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL arst_immediate: got v=%b busy=%b expected 0/0", bus.rsp_valid, busy); end
    n_tests++; if (bus.rsp_data !== 8'h00 || bus.rsp_ch !== 2'd0 || bus.req_ready !== 4'h0)
      begin n_fail++; $display("FAIL arst_fields: got data=%h ch=%0d ready=%b expected 00/0/0000", bus.rsp_data, bus.rsp_ch, bus.req_ready); end
    #2;
    clear_reqs();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL arst_no_stale: got v=%b busy=%b expected 0/0", bus.rsp_valid, busy); end
    set_req(3, 3'b111, 8'hAA, 8'h00);
    set_req(0, 3'b010, 8'h3C, 8'h0F);
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_priority: got %b expected 0001", bus.req_ready); end
    tick();
    clear_reqs();
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'd0 || bus.rsp_data !== 8'h0C)
      begin n_fail++; $display("FAIL arst_first_rsp: got v=%b ch=%0d data=%h expected 1/0/0C", bus.rsp_valid, bus.rsp_ch, bus.rsp_data); end
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   ptr = 3;
    int   edges = 0;
    int   win;
    int   c;
    bit   allowed;
    bit   exp_v;
    logic [3:0] exp_ready;
    int   ops [4];
    int   av [4];
    int   bv [4];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_reqs();
      for (int i = 0; i < 4; i++) begin
        ops[i] = int'($urandom_range(0, 7));
        av[i]  = int'($urandom_range(0, 255));
        bv[i]  = int'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 6) set_req(i, 3'(ops[i]), 8'(av[i]), 8'(bv[i]));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      allowed = (q.size() < 2) || bus.rsp_ready;
      win = -1;
      for (int off = 1; off <= 4; off++) begin
        c = (ptr + off) % 4;
        if (win < 0 && bus.req_valid[c]) win = c;
      end
      exp_ready = (allowed && win >= 0) ? (4'b0001 << win) : 4'b0000;
      n_tests++; if (bus.req_ready !== exp_ready)
        begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, bus.req_ready, exp_ready); end
      exp_v = (q.size() > 0) && (edges >= q[0].t + 2);
      n_tests++; if (bus.rsp_valid !== exp_v)
        begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, bus.rsp_valid, exp_v); end
      if (exp_v) begin
        n_tests++; if (int'(bus.rsp_data) != q[0].data || int'(bus.rsp_ch) != q[0].ch || bus.rsp_carry !== q[0].carry || bus.rsp_zero !== (q[0].data == 0))
          begin n_fail++; $display("FAIL rand_rsp[%0d]: got data=%h ch=%0d c=%b z=%b expected %h/%0d/%b/%b", cyc, bus.rsp_data, bus.rsp_ch, bus.rsp_carry, bus.rsp_zero, q[0].data, q[0].ch, q[0].carry, q[0].data == 0); end
      end
      tick();
      if (exp_v && bus.rsp_ready) void'(q.pop_front());
      if (exp_ready != 4'b0000) begin
        e.ch = win;
        e.t  = edges;
        ref_alu(ops[win], av[win], bv[win], e.data, e.carry);
        q.push_back(e);
        ptr = win;
      end
      edges++;
    end
    clear_reqs();
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    clear_reqs();
    bus.rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_hold();
    test_round_robin();
    test_op_sweep();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
